seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clocks per digit slot (1 kHz digit rate at 50 MHz CP); legal range >= 2.
REQ-002 Parameter BLINK_FRAMES, default 125, scan frames per blink half-period; legal range >= 1.
REQ-003 CP  in  1  clock; all state changes on its rising edge.
REQ-004 CR  in  1  reset; synchronous, active-high.
REQ-005 EN  in  1  display enable; low freezes scanning and blanks the display.
REQ-006 D0, D1, D2, D3  in  4 each  BCD digits from the counter stages; D0 is rightmost.
REQ-007 DP_IN  in  4  decimal-point request per digit, bit i for digit i.
REQ-008 BLINK_MASK  in  4  digits to flash, bit i for digit i; used for time-set mode.
REQ-009 AN  out  4  anode selects, active-low, AN[i] drives digit i.
REQ-010 SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 DP  out  1  decimal point, active-low.
REQ-012 FRAME  out  1  one-cycle pulse at each scan-frame start.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 while EN=1, wrap to 0, and assert an internal tick on the cycle its count equals SCAN_DIV-1.
REQ-014 The 2-bit digit index SHALL increment on each tick and wrap 3->0.
REQ-015 On the edge where the index wraps 3->0, the block SHALL snapshot D0..D3, DP_IN and BLINK_MASK into shadow registers; input changes at any other time SHALL NOT affect the display until the next snapshot.
REQ-016 FRAME SHALL be 1 for exactly the cycle after a snapshot edge, else 0.
REQ-017 The blink counter SHALL count snapshot edges 0..BLINK_FRAMES-1 and toggle blink phase on wrap; phase 1 is dark.
REQ-018 AN, SEG and DP SHALL be registered with one cycle of latency from the index/shadow state.
REQ-019 For index i: AN = all 1 except bit i = 0, unless shadow BLINK_MASK[i]=1 and phase=1, in which case AN=4'b1111.
REQ-020 SEG decode (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; codes 10..15 SHALL give 7F (blank).
REQ-021 DP SHALL equal NOT shadow DP_IN[i].
REQ-022 With EN=0, prescaler, index, blink counter, phase and shadows SHALL hold; AN=1111, SEG=7F, DP=1, FRAME=0 from the next edge.
REQ-023 On EN 0->1, scanning SHALL resume from the held index and prescale count.
REQ-024 CR SHALL take priority over EN and all other inputs.

Reset
REQ-025 While CR=1 at an edge: prescaler=0, index=0, blink count=0, phase=0, all shadows=0, AN=1111, SEG=7F, DP=1, FRAME=0.
REQ-026 After reset the display SHALL show shadow zeros, i.e. "0000" with DPs off, until the first snapshot.
REQ-027 Asserting CR mid-frame SHALL restore REQ-025 values on that same edge.

Structure
REQ-028 The segment patterns (digits 0..9), SEG_BLANK=7F and AN_OFF=1111 SHALL be constants in the shared package clock_disp_pkg.
REQ-029 BCD-to-segment decode SHALL be a combinational sub-module seg7_decode (4-bit in, 7-bit active-low out).
REQ-030 The prescaler width SHALL be clog2(SCAN_DIV); the blink counter width SHALL be clog2(BLINK_FRAMES+1).

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset: CR=1 for 2 cycles, then 0 with EN=1 -> AN=1111, SEG=7F, DP=1 during reset; AN steps 1110,1101,1011,0111 every 4 clocks; SEG=40 until the first FRAME.
REQ-032 Scan: D3..D0=1,2,5,9 held -> after the first FRAME, SEG=10,12,24,79 with AN=1110,1101,1011,0111 respectively, repeating every 16 clocks.
REQ-033 Invalid BCD / DP: D0=A, DP_IN=0001 -> SEG=7F and DP=0 while AN=1110; DP=1 on the other digits.
REQ-034 Blink: BLINK_MASK=0011 -> digits 0,1 have AN bits high for 2 frames, lit for 2 frames, alternating; digits 2,3 are lit every frame.
REQ-035 EN/mid-frame: EN=0 for 10 cycles at index 2 -> AN=1111; on re-enable, index 2 resumes with its remaining count. D0 changed at index 2 -> new value appears only after the next FRAME.
REQ-036 Reset mid-operation: CR=1 for one cycle at index 2 -> next edge gives REQ-025 values; scan restarts at AN=1110.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared display constants and types for the clock's multiplexed 7-segment front end.
// Segment bits are {g,f,e,d,c,b,a}, active-low.
package clock_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Per-frame snapshot of everything the display shows
  typedef struct packed {
    logic [3:0][3:0] dig;
    logic [3:0]      dp;
    logic [3:0]      blink;
  } shadow_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decode; codes 10..15 blank the digit.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_PAT[bcd];
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot and
// per-digit blink for time-set mode. Outputs are registered one cycle behind state.
module seg7_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DP_IN,
  input  logic [3:0] BLINK_MASK,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       FRAME
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0] psc;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;
  shadow_t       sh;

  logic          tick, wrap;
  logic [6:0]    seg_dec;
  logic [3:0]    an_nxt;

  assign tick = EN && (psc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge CP) begin
    if (CR) begin
      psc   <= '0;
      idx   <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      sh    <= '0;
    end else if (EN) begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) idx <= idx + 1'b1;
      // New frame: latch inputs so a digit never changes mid-scan
      if (wrap) begin
        sh.dig   <= {D3, D2, D1, D0};
        sh.dp    <= DP_IN;
        sh.blink <= BLINK_MASK;
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  seg7_decode u_dec (
    .bcd (sh.dig[idx]),
    .seg (seg_dec)
  );

  always_comb begin
    an_nxt = ~(4'b0001 << idx);
    if (sh.blink[idx] && phase) an_nxt = AN_OFF;
  end

  always_ff @(posedge CP) begin
    if (CR || !EN) begin
      AN    <= AN_OFF;
      SEG   <= SEG_BLANK;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      AN    <= an_nxt;
      SEG   <= seg_dec;
      DP    <= ~sh.dp[idx];
      FRAME <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized check of seg7_scan against a model that derives slot, frame and
// blink phase arithmetically from the count of enabled clocks since reset.
module tb_seg7_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       CP = 1'b0;
  logic       CR, EN;
  logic [3:0] D0, D1, D2, D3, DP_IN, BLINK_MASK;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP, FRAME;

  seg7_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .CP(CP), .CR(CR), .EN(EN),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .DP_IN(DP_IN), .BLINK_MASK(BLINK_MASK),
    .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
  );

  always #5 CP = ~CP;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int seg_ref(input int v);
    case (v)
      0: return 'h40; 1: return 'h79; 2: return 'h24; 3: return 'h30;
      4: return 'h19; 5: return 'h12; 6: return 'h02; 7: return 'h78;
      8: return 'h00; 9: return 'h10;
      default: return 'h7F;
    endcase
  endfunction

  // Reference state: n = enabled clocks since reset; shadows as plain ints
  int n;
  int sh_d[4];
  int sh_dp[4];
  int sh_bl[4];
  int e_an, e_seg, e_dp, e_frame;

  task automatic model_step();
    int slot, snaps, ph;
    if (CR) begin
      n = 0;
      for (int i = 0; i < 4; i++) begin sh_d[i] = 0; sh_dp[i] = 0; sh_bl[i] = 0; end
      e_an = 'hF; e_seg = 'h7F; e_dp = 1; e_frame = 0;
    end else if (EN) begin
      slot  = (n / SD) % 4;
      snaps = n / (4 * SD);
      ph    = (snaps / BF) % 2;
      e_an    = (sh_bl[slot] != 0 && ph == 1) ? 'hF : ('hF & ~(1 << slot));
      e_seg   = seg_ref(sh_d[slot]);
      e_dp    = (sh_dp[slot] != 0) ? 0 : 1;
      e_frame = ((n % (4 * SD)) == 4 * SD - 1) ? 1 : 0;
      if (e_frame == 1) begin
        sh_d[0] = int'(D0); sh_d[1] = int'(D1); sh_d[2] = int'(D2); sh_d[3] = int'(D3);
        for (int i = 0; i < 4; i++) begin
          sh_dp[i] = int'(DP_IN[i]);
          sh_bl[i] = int'(BLINK_MASK[i]);
        end
      end
      n++;
    end else begin
      e_an = 'hF; e_seg = 'h7F; e_dp = 1; e_frame = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CP);
    model_step();
    #1;
    chk("AN",    32'(AN),    32'(e_an));
    chk("SEG",   32'(SEG),   32'(e_seg));
    chk("DP",    32'(DP),    32'(e_dp));
    chk("FRAME", 32'(FRAME), 32'(e_frame));
  endtask

  int off_left;

  initial begin
    n = 0; off_left = 0;
    for (int i = 0; i < 4; i++) begin sh_d[i] = 0; sh_dp[i] = 0; sh_bl[i] = 0; end
    CR = 1'b1; EN = 1'b1;
    D3 = 4'd1; D2 = 4'd2; D1 = 4'd5; D0 = 4'd9;
    DP_IN = 4'b0000; BLINK_MASK = 4'b0000;

    // Reset, then a steady display of 1259
    repeat (2) begin @(negedge CP); cycle(); end
    @(negedge CP); CR = 1'b0;
    repeat (80) begin cycle(); @(negedge CP); end

    // Invalid code and DP on digit 0, blink on digits 0,1
    D0 = 4'hA; DP_IN = 4'b0001; BLINK_MASK = 4'b0011;
    repeat (160) begin cycle(); @(negedge CP); end

    // Random traffic including enable gaps and mid-frame resets
    repeat (3000) begin
      CR = ($urandom_range(0, 299) == 0);
      if (off_left > 0) begin
        off_left--;
        EN = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        off_left = $urandom_range(1, 12);
        EN = 1'b0;
      end else begin
        EN = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: D0 = 4'($urandom_range(0, 15));
          1: D1 = 4'($urandom_range(0, 15));
          2: D2 = 4'($urandom_range(0, 15));
          default: D3 = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 29) == 0) DP_IN = 4'($urandom);
      if ($urandom_range(0, 59) == 0) BLINK_MASK = 4'($urandom);
      cycle();
      @(negedge CP);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
